// File: rtl/alarm_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : alarm_sequencer_if
// Brief   : Time/button inputs and status outputs of the alarm sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alarm_sequencer_if;
    logic        SEC_TICK;
    logic        ALARM_EN;
    logic [16:0] CURRENT_TIME;
    logic [16:0] ALARM_TIME;
    logic        STOP_BTN;
    logic        SNOOZE_BTN;
    logic        BUZZER_EN;
    logic [2:0]  ALARM_STATE;
    logic [1:0]  SNOOZE_CNT;
    logic [16:0] NEXT_ALARM;

    // master drives time and buttons, slave is the sequencer
    modport master (
        output SEC_TICK, ALARM_EN, CURRENT_TIME, ALARM_TIME, STOP_BTN, SNOOZE_BTN,
        input  BUZZER_EN, ALARM_STATE, SNOOZE_CNT, NEXT_ALARM
    );

    modport slave (
        input  SEC_TICK, ALARM_EN, CURRENT_TIME, ALARM_TIME, STOP_BTN, SNOOZE_BTN,
        output BUZZER_EN, ALARM_STATE, SNOOZE_CNT, NEXT_ALARM
    );
endinterface

`default_nettype wire

// File: rtl/alarm_sequencer.sv
//------------------------------------------------------------------------------
// Module  : alarm_sequencer
// Brief   : Alarm clock state machine with snooze, ring timeout and holdoff.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alarm_sequencer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  wire logic         CLK,
    input  wire logic         RESETN,
    alarm_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_RINGING  = 3'd2,
        S_SNOOZING = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    localparam logic [17:0] c_snooze_sec   = 18'(SNOOZE_SEC);
    localparam logic [17:0] c_day_sec      = 18'd86400;
    localparam logic [5:0]  c_ring_last    = 6'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0]  c_max_snooze   = 2'(MAX_SNOOZE);

    state_t      r_state;
    logic        r_buzzer;
    logic [1:0]  r_snooze_cnt;
    logic [5:0]  r_ring_cnt;
    logic [16:0] r_snooze_target;

    state_t      w_state_nxt;
    logic [1:0]  w_snooze_cnt_nxt;
    logic [5:0]  w_ring_cnt_nxt;
    logic [16:0] w_snooze_target_nxt;
    logic [16:0] w_next_alarm;
    logic [17:0] w_snooze_sum;
    logic [16:0] w_snooze_calc;

    assign w_next_alarm = (r_snooze_cnt == 2'd0) ? bus.ALARM_TIME : r_snooze_target;
    assign w_snooze_sum = {1'b0, bus.CURRENT_TIME} + c_snooze_sec;

    // wrap the snooze target across midnight
    always_comb begin
        w_snooze_calc = w_snooze_sum[16:0];
        if (w_snooze_sum >= c_day_sec) begin
            w_snooze_calc = 17'(w_snooze_sum - c_day_sec);
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_snooze_cnt_nxt    = r_snooze_cnt;
        w_ring_cnt_nxt      = r_ring_cnt;
        w_snooze_target_nxt = r_snooze_target;

        if (!bus.ALARM_EN) begin
            w_state_nxt      = S_IDLE;
            w_snooze_cnt_nxt = 2'd0;
            w_ring_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (bus.CURRENT_TIME == w_next_alarm) begin
                        w_state_nxt    = S_RINGING;
                        w_ring_cnt_nxt = 6'd0;
                    end
                end
                S_RINGING: begin
                    // stop beats snooze, any accepted button beats the timeout
                    if (bus.STOP_BTN) begin
                        w_state_nxt      = S_HOLDOFF;
                        w_snooze_cnt_nxt = 2'd0;
                        w_ring_cnt_nxt   = 6'd0;
                    end else if (bus.SNOOZE_BTN && (r_snooze_cnt < c_max_snooze)) begin
                        w_state_nxt         = S_SNOOZING;
                        w_snooze_cnt_nxt    = r_snooze_cnt + 2'd1;
                        w_snooze_target_nxt = w_snooze_calc;
                        w_ring_cnt_nxt      = 6'd0;
                    end else if (bus.SEC_TICK) begin
                        if (r_ring_cnt == c_ring_last) begin
                            w_state_nxt      = S_HOLDOFF;
                            w_snooze_cnt_nxt = 2'd0;
                            w_ring_cnt_nxt   = 6'd0;
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt + 6'd1;
                        end
                    end
                end
                S_SNOOZING: begin
                    if (bus.STOP_BTN) begin
                        w_state_nxt      = S_HOLDOFF;
                        w_snooze_cnt_nxt = 2'd0;
                    end else if (bus.CURRENT_TIME == r_snooze_target) begin
                        w_state_nxt    = S_RINGING;
                        w_ring_cnt_nxt = 6'd0;
                    end
                end
                S_HOLDOFF: begin
                    // wait out the matching second so the alarm cannot re-fire
                    if (bus.CURRENT_TIME != bus.ALARM_TIME) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                default: begin
                    w_state_nxt      = S_IDLE;
                    w_snooze_cnt_nxt = 2'd0;
                    w_ring_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state         <= S_IDLE;
            r_buzzer        <= 1'b0;
            r_snooze_cnt    <= 2'd0;
            r_ring_cnt      <= 6'd0;
            r_snooze_target <= 17'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_buzzer        <= (w_state_nxt == S_RINGING);
            r_snooze_cnt    <= w_snooze_cnt_nxt;
            r_ring_cnt      <= w_ring_cnt_nxt;
            r_snooze_target <= w_snooze_target_nxt;
        end
    end

    assign bus.BUZZER_EN   = r_buzzer;
    assign bus.ALARM_STATE = r_state;
    assign bus.SNOOZE_CNT  = r_snooze_cnt;
    assign bus.NEXT_ALARM  = w_next_alarm;

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_alarm_sequencer
// Brief   : Directed self-checking bench for alarm_sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alarm_sequencer;

    logic CLK;
    logic RESETN;
    int   n_checks;
    int   n_errors;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .SNOOZE_SEC       (300),
        .RING_TIMEOUT_SEC (60),
        .MAX_SNOOZE       (3)
    ) u_dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int st, input int bz, input int cnt);
        chk({tag, ".state"}, 32'(bus.ALARM_STATE), 32'(st));
        chk({tag, ".buzz"},  32'(bus.BUZZER_EN),   32'(bz));
        chk({tag, ".scnt"},  32'(bus.SNOOZE_CNT),  32'(cnt));
    endtask

    // one clock, then settle past the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_snooze();
        bus.SNOOZE_BTN = 1'b1;
        step();
        bus.SNOOZE_BTN = 1'b0;
    endtask

    task automatic press_stop();
        bus.STOP_BTN = 1'b1;
        step();
        bus.STOP_BTN = 1'b0;
    endtask

    task automatic sec_pulse();
        bus.SEC_TICK = 1'b1;
        step();
        bus.SEC_TICK = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        RESETN           = 1'b0;
        bus.SEC_TICK     = 1'b0;
        bus.ALARM_EN     = 1'b1;
        bus.CURRENT_TIME = 17'd0;
        bus.ALARM_TIME   = 17'd25200;
        bus.STOP_BTN     = 1'b1;
        bus.SNOOZE_BTN   = 1'b1;

        // reset overrides enable and buttons
        step();
        step();
        chk_status("reset", 0, 0, 0);
        chk("reset.next", 32'(bus.NEXT_ALARM), 32'd25200);

        bus.STOP_BTN   = 1'b0;
        bus.SNOOZE_BTN = 1'b0;
        RESETN         = 1'b1;
        bus.CURRENT_TIME = 17'd25199;
        step();
        chk_status("arm", 1, 0, 0);

        // alarm time is followed live while armed
        bus.ALARM_TIME = 17'd25201;
        bus.CURRENT_TIME = 17'd25200;
        step();
        chk_status("nomatch", 1, 0, 0);
        bus.ALARM_TIME = 17'd25200;
        step();
        chk_status("ring1", 2, 1, 0);

        bus.CURRENT_TIME = 17'd25205;
        press_snooze();
        chk_status("snz1", 3, 0, 1);
        chk("snz1.next", 32'(bus.NEXT_ALARM), 32'd25505);
        bus.CURRENT_TIME = 17'd25400;
        step();
        chk_status("snz1.wait", 3, 0, 1);
        bus.CURRENT_TIME = 17'd25505;
        step();
        chk_status("ring2", 2, 1, 1);

        press_snooze();
        chk("snz2.next", 32'(bus.NEXT_ALARM), 32'd25805);
        bus.CURRENT_TIME = 17'd25805;
        step();
        press_snooze();
        chk_status("snz3", 3, 0, 3);
        chk("snz3.next", 32'(bus.NEXT_ALARM), 32'd26105);
        press_snooze();
        chk_status("snz3.ignored", 3, 0, 3);
        bus.CURRENT_TIME = 17'd26105;
        step();
        chk_status("ring4", 2, 1, 3);
        press_snooze();
        chk_status("snz4.ignored", 2, 1, 3);

        bus.STOP_BTN = 1'b1;
        press_snooze();
        bus.STOP_BTN = 1'b0;
        chk_status("stopwins", 4, 0, 0);
        chk("stopwins.next", 32'(bus.NEXT_ALARM), 32'd25200);
        step();
        chk_status("rearm", 1, 0, 0);
        press_stop();
        press_snooze();
        chk_status("armed.btn", 1, 0, 0);

        // ring timeout after exactly 60 second ticks
        bus.CURRENT_TIME = 17'd25200;
        step();
        chk_status("ring5", 2, 1, 0);
        for (int i = 0; i < 59; i++) sec_pulse();
        chk_status("tick59", 2, 1, 0);
        bus.SEC_TICK = 1'b1;
        step();
        bus.SEC_TICK = 1'b0;
        chk_status("tick60", 4, 0, 0);
        step();
        step();
        chk_status("holdoff", 4, 0, 0);
        bus.CURRENT_TIME = 17'd25201;
        step();
        chk_status("holdoff.exit", 1, 0, 0);
        step();
        step();
        chk_status("noreing", 1, 0, 0);

        // snooze across midnight
        bus.ALARM_TIME = 17'd86300;
        bus.CURRENT_TIME = 17'd86300;
        step();
        chk_status("ring6", 2, 1, 0);
        bus.CURRENT_TIME = 17'd86350;
        press_snooze();
        chk("wrap.next", 32'(bus.NEXT_ALARM), 32'd250);
        bus.CURRENT_TIME = 17'd249;
        step();
        chk_status("wrap.wait", 3, 0, 1);
        bus.CURRENT_TIME = 17'd250;
        step();
        chk_status("wrap.ring", 2, 1, 1);

        press_stop();
        chk_status("stop2", 4, 0, 0);
        step();
        chk_status("rearm2", 1, 0, 0);
        bus.ALARM_TIME = 17'd86100;
        bus.CURRENT_TIME = 17'd86100;
        step();
        press_snooze();
        chk("wrap0.next", 32'(bus.NEXT_ALARM), 32'd0);
        bus.CURRENT_TIME = 17'd0;
        step();
        chk_status("wrap0.ring", 2, 1, 1);
        bus.CURRENT_TIME = 17'd86099;
        press_snooze();
        chk("last.next", 32'(bus.NEXT_ALARM), 32'd86399);
        chk_status("last.snz", 3, 0, 2);

        // enable drop while snoozing
        bus.ALARM_EN = 1'b0;
        step();
        chk_status("disable", 0, 0, 0);

        // reset while ringing
        bus.ALARM_EN = 1'b1;
        step();
        bus.CURRENT_TIME = 17'd86100;
        step();
        chk_status("ring7", 2, 1, 0);
        RESETN = 1'b0;
        step();
        chk_status("reset.ring", 0, 0, 0);
        RESETN = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze delay in seconds (1..3599).
REQ-002 Parameter RING_TIMEOUT_SEC, default 60, maximum ring duration in seconds (1..63).
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event (0..3).
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 RESETN  in  1  reset, synchronous, active-low.
REQ-006 SEC_TICK  in  1  one-cycle pulse, once per second.
REQ-007 ALARM_EN  in  1  level; 1 = alarm function enabled.
REQ-008 CURRENT_TIME  in  17  seconds-of-day, 0..86399.
REQ-009 ALARM_TIME  in  17  user alarm time, seconds-of-day, 0..86399.
REQ-010 STOP_BTN  in  1  one-cycle debounced pulse, stop ringing.
REQ-011 SNOOZE_BTN  in  1  one-cycle debounced pulse, snooze ringing.
REQ-012 BUZZER_EN  out  1  registered; 1 exactly while state is RINGING.
REQ-013 ALARM_STATE  out  3  registered state: IDLE=0, ARMED=1, RINGING=2, SNOOZING=3, HOLDOFF=4.
REQ-014 SNOOZE_CNT  out  2  snoozes taken in current alarm event.
REQ-015 NEXT_ALARM  out  17  active target: ALARM_TIME when SNOOZE_CNT=0, else snooze target register.

Function
REQ-016 ALARM_EN=0 in any state SHALL force IDLE, BUZZER_EN=0, SNOOZE_CNT=0, ring counter=0 on the next edge; highest priority after reset.
REQ-017 IDLE -> ARMED on the edge after ALARM_EN=1 is sampled.
REQ-018 ARMED -> RINGING on the edge after a cycle with CURRENT_TIME==NEXT_ALARM (1-cycle latency); compare every cycle, not gated by SEC_TICK.
REQ-019 ALARM_TIME changes while ARMED with SNOOZE_CNT=0 SHALL take effect for the next cycle's compare; no latching.
REQ-020 On RINGING entry the 6-bit ring counter SHALL clear; it increments on each SEC_TICK while RINGING.
REQ-021 RINGING, STOP_BTN=1 -> HOLDOFF; SNOOZE_CNT cleared.
REQ-022 RINGING, SNOOZE_BTN=1, STOP_BTN=0, SNOOZE_CNT<MAX_SNOOZE -> SNOOZING; SNOOZE_CNT+1; snooze target = CURRENT_TIME+SNOOZE_SEC computed in 18 bits, minus 86400 if result >=86400.
REQ-023 SNOOZE_BTN with SNOOZE_CNT==MAX_SNOOZE SHALL be ignored; ringing continues.
REQ-024 STOP_BTN and SNOOZE_BTN in the same cycle: STOP wins.
REQ-025 RINGING, SEC_TICK=1 with ring counter==RING_TIMEOUT_SEC-1 and no button -> HOLDOFF, SNOOZE_CNT cleared (exactly RING_TIMEOUT_SEC ticks of ringing); a button in the same cycle takes precedence.
REQ-026 SNOOZING -> RINGING on the edge after CURRENT_TIME==snooze target; STOP_BTN while SNOOZING -> HOLDOFF, SNOOZE_CNT cleared; SNOOZE_BTN ignored.
REQ-027 HOLDOFF -> ARMED on the edge after CURRENT_TIME!=ALARM_TIME, preventing re-trigger within the matching second.
REQ-028 Buttons SHALL be ignored in IDLE, ARMED, HOLDOFF.
REQ-029 Snooze target wrap across midnight SHALL be exact (86399+1 -> 0).

Reset
REQ-030 RESETN=0 sampled on an edge SHALL set ALARM_STATE=IDLE, BUZZER_EN=0, SNOOZE_CNT=0, ring counter=0, snooze target=0, regardless of state including mid-ring or mid-snooze.
REQ-031 Reset SHALL override ALARM_EN and all button inputs in the same cycle.

Verification
REQ-032 ALARM_EN=1, ALARM_TIME=25200, CURRENT_TIME steps to 25200 -> BUZZER_EN=1 one cycle later, ALARM_STATE=2.
REQ-033 Ringing at CURRENT_TIME=25205, SNOOZE_BTN pulse -> ALARM_STATE=3, SNOOZE_CNT=1, NEXT_ALARM=25505; CURRENT_TIME=25505 -> ring resumes.
REQ-034 ALARM_TIME=86300, ring, snooze at CURRENT_TIME=86350 -> NEXT_ALARM=250; ring at CURRENT_TIME=250.
REQ-035 Ring with no buttons for 60 SEC_TICKs -> BUZZER_EN=0 after 60th tick, ALARM_STATE=4, then 1 once CURRENT_TIME=25201; no re-ring.
REQ-036 STOP_BTN and SNOOZE_BTN same cycle -> HOLDOFF, SNOOZE_CNT=0; fourth SNOOZE_BTN with MAX_SNOOZE=3 -> still RINGING, SNOOZE_CNT=3.
REQ-037 RESETN=0 during RINGING, and ALARM_EN=0 during SNOOZING -> next edge ALARM_STATE=0, BUZZER_EN=0, SNOOZE_CNT=0.
